// File: rtl/gray_pkg.sv
// Shared definitions for the gray column converter: luma coefficients,
// info-byte layout and a reference RGB565 -> 8-bit luma function.
package gray_pkg;

    // Luma weights; they sum to 256 so the >>8 keeps full scale at 255.
    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    // Info byte layout: {rsvd, cam[2:0], third[1:0], sof, eof}
    localparam int unsigned INFO_EOF      = 0;
    localparam int unsigned INFO_SOF      = 1;
    localparam int unsigned INFO_THIRD_LO = 2;
    localparam int unsigned INFO_THIRD_HI = 3;
    localparam int unsigned INFO_CAM_LO   = 4;
    localparam int unsigned INFO_CAM_HI   = 6;

    typedef enum logic [1:0] {
        THIRD_LEFT   = 2'b00,
        THIRD_CENTER = 2'b01,
        THIRD_RIGHT  = 2'b10,
        THIRD_RSVD   = 2'b11
    } third_e;

    typedef struct packed {
        logic       rsvd;
        logic [2:0] cam;
        third_e     third;
        logic       sof;
        logic       eof;
    } info_t;

    // Replicate the top bits so 5/6-bit full scale maps onto 255.
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

    function automatic logic [7:0] rgb565_to_y(input logic [15:0] px);
        logic [15:0] sum;
        sum = 16'(expand5(px[15:11])) * 16'(COEF_R)
            + 16'(expand6(px[10:5]))  * 16'(COEF_G)
            + 16'(expand5(px[4:0]))   * 16'(COEF_B);
        return 8'(sum >> 8);
    endfunction

endpackage

// File: rtl/gray_out_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// Ports: pclk/pclk_reset (sync clear), i_push/i_data write side,
// i_pop read side, o_data head word, o_valid head present,
// o_full, o_count occupancy.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module gray_out_fifo #(
    parameter int unsigned WIDTH = 136,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       pclk,
    input  logic                       pclk_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge pclk) begin
        if (pclk_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge pclk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = !w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule

// File: rtl/gray_column_converter.sv
// Converts 16 RGB565 pixels per column word to 8-bit luma through a
// two-stage pipeline, checks SOF/EOF sequencing and buffers results.
// Ports: pclk/pclk_reset; in_data/in_valid from the column reader with
// in_almost_full backpressure; out_data/out_info/out_valid/out_ready
// show-ahead output; frame_done pulse; sticky seq_error and overflow.
module gray_column_converter
    import gray_pkg::*;
#(
    parameter int unsigned frame_lines       = 480,
    parameter int unsigned frame_third_width = 240,
    parameter int unsigned center_width      = 304,
    parameter int unsigned fifo_depth        = 8
) (
    input  logic         pclk,
    input  logic         pclk_reset,
    input  logic [263:0] in_data,
    input  logic         in_valid,
    output logic         in_almost_full,
    output logic [127:0] out_data,
    output logic [7:0]   out_info,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_done,
    output logic         seq_error,
    output logic         overflow
);

    localparam int unsigned CW    = $clog2(fifo_depth) + 1;
    localparam int unsigned OCC_W = CW + 1;
    localparam logic [9:0] LAST_LINE    = 10'(frame_lines - 1);
    localparam logic [7:0] END_COL_CTR  = 8'(center_width / 16 - 1);
    localparam logic [7:0] END_COL_SIDE = 8'(frame_third_width / 16 - 1);

    info_t w_in_info;
    assign w_in_info = info_t'(in_data[263:256]);

    // Stage 1: per-channel products
    logic [15:0] r_s1_pr [16];
    logic [15:0] r_s1_pg [16];
    logic [15:0] r_s1_pb [16];
    info_t       r_s1_info;
    logic        r_s1_valid;

    // Stage 2: truncated luma
    logic [127:0] r_s2_gray;
    info_t        r_s2_info;
    logic         r_s2_valid;

    always_ff @(posedge pclk) begin
        if (pclk_reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge pclk) begin
        r_s1_info <= w_in_info;
        r_s2_info <= r_s1_info;
        for (int unsigned i = 0; i < 16; i++) begin
            r_s1_pr[i] <= 16'(expand5(in_data[16*i+11 +: 5])) * 16'(COEF_R);
            r_s1_pg[i] <= 16'(expand6(in_data[16*i+5  +: 6])) * 16'(COEF_G);
            r_s1_pb[i] <= 16'(expand5(in_data[16*i    +: 5])) * 16'(COEF_B);
            r_s2_gray[8*i +: 8] <= 8'((r_s1_pr[i] + r_s1_pg[i] + r_s1_pb[i]) >> 8);
        end
    end

    // Sequence checker
    logic [9:0] r_line_cnt;
    logic [7:0] r_col_cnt;
    logic       r_seq_error;
    logic [7:0] w_end_col;
    logic       w_exp_sof;
    logic       w_exp_eof;

    assign w_end_col = (w_in_info.third == THIRD_CENTER) ? END_COL_CTR : END_COL_SIDE;
    assign w_exp_sof = (r_line_cnt == '0) && (r_col_cnt == '0);
    assign w_exp_eof = (r_line_cnt == LAST_LINE) && (r_col_cnt == w_end_col);

    always_ff @(posedge pclk) begin
        if (pclk_reset) begin
            r_line_cnt  <= '0;
            r_col_cnt   <= '0;
            r_seq_error <= 1'b0;
        end else if (in_valid) begin
            if ((w_in_info.sof != w_exp_sof) || (w_in_info.eof != w_exp_eof))
                r_seq_error <= 1'b1;
            // sof resynchronises to the state after a frame's first word
            if (w_in_info.sof) begin
                r_line_cnt <= 10'd1;
                r_col_cnt  <= '0;
            end else if (w_in_info.eof) begin
                r_line_cnt <= '0;
                r_col_cnt  <= '0;
            end else if (r_line_cnt == LAST_LINE) begin
                r_line_cnt <= '0;
                r_col_cnt  <= r_col_cnt + 8'd1;
            end else begin
                r_line_cnt <= r_line_cnt + 10'd1;
            end
        end
    end

    // Output FIFO
    logic [135:0]  w_fifo_rdata;
    logic          w_fifo_valid;
    logic          w_fifo_full;
    logic [CW-1:0] w_fifo_count;
    logic          w_pop;
    info_t         w_head_info;

    assign w_pop       = w_fifo_valid && out_ready;
    assign w_head_info = info_t'(w_fifo_rdata[135:128]);

    gray_out_fifo #(
        .WIDTH (136),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .pclk       (pclk),
        .pclk_reset (pclk_reset),
        .i_push     (r_s2_valid),
        .i_data     ({r_s2_info, r_s2_gray}),
        .i_pop      (w_pop),
        .o_data     (w_fifo_rdata),
        .o_valid    (w_fifo_valid),
        .o_full     (w_fifo_full),
        .o_count    (w_fifo_count)
    );

    // Credit: words already committed to the FIFO or still in the pipeline
    logic [OCC_W-1:0] w_occ;
    logic             r_almost_full;
    logic             r_overflow;
    logic             r_frame_done;

    assign w_occ = OCC_W'(w_fifo_count) + OCC_W'(r_s1_valid) + OCC_W'(r_s2_valid);

    always_ff @(posedge pclk) begin
        if (pclk_reset) begin
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_almost_full <= (w_occ >= OCC_W'(fifo_depth - 4));
            if (r_s2_valid && w_fifo_full && !w_pop)
                r_overflow <= 1'b1;
            r_frame_done <= w_pop && w_head_info.eof;
        end
    end

    assign in_almost_full = r_almost_full;
    assign out_data       = w_fifo_rdata[127:0];
    assign out_info       = w_fifo_rdata[135:128];
    assign out_valid      = w_fifo_valid;
    assign frame_done     = r_frame_done;
    assign seq_error      = r_seq_error;
    assign overflow       = r_overflow;

endmodule
